// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch/sequence controller.
// The word step is also used by the external PC update block.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALTED = 3'd4,
        ST_FAULT  = 3'd5
    } seqState_t;

    localparam logic [1:0]  FC_NONE     = 2'b00;
    localparam logic [1:0]  FC_TIMEOUT  = 2'b01;
    localparam logic [1:0]  FC_MISALIGN = 2'b10;

    localparam logic [31:0] WORD_STEP   = 32'h0000_0004;

endpackage

// File: rtl/fetch_timeout_counter.sv
// 8-bit fetch wait counter with terminal-count compare against MEM_TIMEOUT-1.
// Clear has priority over enable.
module fetch_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [7:0] LAST_COUNT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign terminal = (count == LAST_COUNT);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/sequence controller owning the architectural PC.
//   state     | meaning
//   ST_FETCH  | imem_req high, wait for imem_ready (timeout -> ST_FAULT)
//   ST_ISSUE  | one-cycle instr_valid pulse
//   ST_EXEC   | wait for exec_done from the datapath
//   ST_UPDATE | commit pc_next_in, bump retired, check alignment / halt
//   ST_HALTED | stopped on request, terminal until reset
//   ST_FAULT  | stopped on fault, terminal until reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    output logic [31:0] pc_out,
    output logic [25:0] ins_offset,
    input  logic [31:0] pc_next_in,
    input  logic        halt,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    seqState_t   state;
    seqState_t   stateNext;
    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic [31:0] retiredReg;
    logic [1:0]  faultCode;
    logic        timeoutHit;
    logic        misaligned;
    logic        inFetch;

    assign inFetch    = (state == ST_FETCH);
    assign misaligned = ALIGN_CHECK && (pc_next_in[1:0] != 2'b00);

    fetch_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) uTimeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (!inFetch || imem_ready),
        .enable   (inFetch),
        .terminal (timeoutHit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_FETCH: begin
                if (imem_ready) begin
                    stateNext = ST_ISSUE;
                end else if (timeoutHit) begin
                    stateNext = ST_FAULT;
                end
            end
            ST_ISSUE:  stateNext = ST_EXEC;
            ST_EXEC: begin
                if (exec_done) begin
                    stateNext = ST_UPDATE;
                end
            end
            // Misalignment outranks a simultaneous halt request.
            ST_UPDATE: begin
                if (misaligned) begin
                    stateNext = ST_FAULT;
                end else if (halt) begin
                    stateNext = ST_HALTED;
                end else begin
                    stateNext = ST_FETCH;
                end
            end
            ST_HALTED: stateNext = ST_HALTED;
            ST_FAULT:  stateNext = ST_FAULT;
            default:   stateNext = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg      <= RESET_PC;
            instrReg   <= 32'd0;
            retiredReg <= 32'd0;
            faultCode  <= FC_NONE;
        end else begin
            if (inFetch && imem_ready) begin
                instrReg <= imem_rdata;
            end
            if (inFetch && !imem_ready && timeoutHit) begin
                faultCode <= FC_TIMEOUT;
            end
            if (state == ST_UPDATE) begin
                pcReg      <= pc_next_in;
                retiredReg <= retiredReg + 32'd1;
                if (misaligned) begin
                    faultCode <= FC_MISALIGN;
                end
            end
        end
    end

    assign imem_req    = inFetch;
    assign imem_addr   = pcReg;
    assign pc_out      = pcReg;
    assign instr       = instrReg;
    assign ins_offset  = instrReg[25:0];
    assign instr_valid = (state == ST_ISSUE);
    assign halted      = (state == ST_HALTED);
    assign fault       = (state == ST_FAULT);
    assign fault_code  = faultCode;
    assign retired     = retiredReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table-driven instruction vectors, an issue scoreboard
// and hand-written timeout / reset-abort sequences.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [31:0] pc_out;
    logic [25:0] ins_offset;
    logic [31:0] pc_next_in;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (16),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pc_out      (pc_out),
        .ins_offset  (ins_offset),
        .pc_next_in  (pc_next_in),
        .halt        (halt),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          resetBefore;
        int          stall;      // FETCH cycles with imem_ready low
        int          execWait;   // EXEC cycles before exec_done
        logic [31:0] rdata;
        logic [31:0] nextPc;
        int          haltMode;   // 0 none, 1 held ISSUE..UPDATE, 2 pulse in FETCH only
        logic [1:0]  expFault;
        bit          expHalted;
    } vec_t;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] modelPc;
    logic [31:0] modelRetired;
    logic [31:0] sbInstr[$];
    vec_t        vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue scoreboard: each delivered word must appear on exactly one instr_valid pulse.
    always @(negedge clk) begin
        if (!reset && instr_valid) begin
            if (sbInstr.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL issue_unexpected: instr_valid with instr %h, none expected", instr);
            end else begin
                logic [31:0] exp;
                exp = sbInstr.pop_front();
                check("issue_instr", instr, exp);
                check("issue_offset", {6'd0, ins_offset}, {6'd0, exp[25:0]});
            end
        end
    end

    task automatic doReset();
        check("sb_drained", sbInstr.size(), 0);
        sbInstr.delete();
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        halt       = 1'b0;
        pc_next_in = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelPc      = 32'h0000_0000;
        modelRetired = 32'd0;
        check("rst_pc", pc_out, 32'h0);
        check("rst_retired", retired, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_flags", {28'd0, instr_valid, halted, fault, imem_req}, 32'h1);
        check("rst_fault_code", {30'd0, fault_code}, {30'd0, FC_NONE});
    endtask

    task automatic runInstr(input vec_t v);
        if (v.resetBefore) doReset();
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, modelPc);
        for (int i = 0; i < v.stall; i++) begin
            imem_ready = 1'b0;
            halt       = (v.haltMode == 2);
            @(negedge clk);
        end
        halt       = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = v.rdata;
        sbInstr.push_back(v.rdata);
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        exec_done  = (v.execWait > 0);   // must be ignored while in ISSUE
        halt       = (v.haltMode == 1);
        @(negedge clk);
        check("valid_one_cycle", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < v.execWait; i++) begin
            exec_done = 1'b0;
            @(negedge clk);
        end
        exec_done  = 1'b1;
        pc_next_in = v.nextPc;
        @(negedge clk);
        exec_done = 1'b0;
        check("pc_before_commit", pc_out, modelPc);
        @(negedge clk);
        modelPc      = v.nextPc;
        modelRetired = modelRetired + 32'd1;
        halt         = 1'b0;
        check("commit_pc", pc_out, modelPc);
        check("commit_retired", retired, modelRetired);
        check("instr_held", instr, v.rdata);
        check("commit_fault_code", {30'd0, fault_code}, {30'd0, v.expFault});
        check("commit_fault", {31'd0, fault}, {31'd0, (v.expFault != FC_NONE)});
        check("commit_halted", {31'd0, halted}, {31'd0, v.expHalted});
        check("commit_req", {31'd0, imem_req},
              {31'd0, (v.expFault == FC_NONE) && !v.expHalted});
        if (v.expFault == FC_NONE && !v.expHalted) begin
            check("next_addr", imem_addr, modelPc);
        end else begin
            for (int i = 0; i < 3; i++) begin
                pc_next_in = 32'h5555_5550 + 32'(i * 4);
                exec_done  = 1'b1;
                imem_ready = 1'b1;
                @(negedge clk);
                check("terminal_req", {31'd0, imem_req}, 32'd0);
                check("terminal_pc", pc_out, modelPc);
                check("terminal_sticky", {29'd0, halted, fault_code},
                      {29'd0, v.expHalted, v.expFault});
            end
            exec_done  = 1'b0;
            imem_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t v;
        vecs = '{
            '{1'b1, 0, 0, 32'h2000_0001, 32'h0000_0004, 0, FC_NONE,     1'b0},
            '{1'b0, 0, 0, 32'h8C41_0004, 32'h0000_0008, 0, FC_NONE,     1'b0},
            '{1'b0, 0, 0, 32'hAC22_0008, 32'h0000_000C, 0, FC_NONE,     1'b0},
            '{1'b0, 5, 2, 32'h0812_53ED, 32'h00A9_4FB4, 0, FC_NONE,     1'b0},
            '{1'b0, 0, 1, 32'h1022_0006, 32'h00AB_0DB8, 0, FC_NONE,     1'b0},
            '{1'b0, 2, 0, 32'h03E0_0008, 32'h00AB_0DBC, 2, FC_NONE,     1'b0},
            '{1'b0, 0, 2, 32'hDEAD_BEEF, 32'h00AB_0DC0, 1, FC_NONE,     1'b1},
            '{1'b1, 0, 0, 32'h0812_53ED, 32'h00A9_4FB4, 0, FC_NONE,     1'b0},
            '{1'b0, 0, 0, 32'h1234_5678, 32'h00A9_4FB6, 0, FC_MISALIGN, 1'b0},
            '{1'b1, 0, 0, 32'h0812_53ED, 32'h00A9_4FB4, 0, FC_NONE,     1'b0},
            '{1'b0, 0, 1, 32'h8765_4321, 32'h00A9_4FB6, 1, FC_MISALIGN, 1'b0}
        };
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        halt       = 1'b0;
        pc_next_in = 32'h0;
        modelPc      = 32'h0;
        modelRetired = 32'd0;
        @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            runInstr(vecs[k]);
            if (k == 2) check("straight_retired", retired, 32'd3);
        end

        // Fetch timeout: imem_ready never rises.
        doReset();
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("timeout_fetch_cycles", 32'(n), 32'd16);
        check("timeout_fault", {31'd0, fault}, 32'd1);
        check("timeout_code", {30'd0, fault_code}, {30'd0, FC_TIMEOUT});
        check("timeout_halted", {31'd0, halted}, 32'd0);
        check("timeout_pc", pc_out, 32'h0);

        // Reset mid-EXEC aborts the instruction without commit.
        doReset();
        v = '{1'b0, 0, 0, 32'h0000_1111, 32'h0000_0004, 0, FC_NONE, 1'b0};
        runInstr(v);
        imem_ready = 1'b1;
        imem_rdata = 32'h2222_3333;
        sbInstr.push_back(32'h2222_3333);
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        exec_done  = 1'b1;
        pc_next_in = 32'h1234_5678;
        @(negedge clk);
        reset     = 1'b0;
        exec_done = 1'b0;
        modelPc      = 32'h0;
        modelRetired = 32'd0;
        check("abort_pc", pc_out, 32'h0);
        check("abort_retired", retired, 32'd0);
        check("abort_req", {31'd0, imem_req}, 32'd1);
        check("abort_instr", instr, 32'd0);
        @(negedge clk);
        check("abort_no_commit", pc_out, 32'h0);
        doReset();
        v = '{1'b0, 1, 0, 32'h0000_4444, 32'h0000_0004, 0, FC_NONE, 1'b0};
        runInstr(v);

        check("sb_final", sbInstr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
